axi_rd_responder: RTL

//  AXI4 read subordinate (AR in, R out) that models the DDR end of the prefetcher's master port.

---
 rtl/axi_rd_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/axi_rd_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI4 read responder.
// The optional LFSR back-pressure feature is selected by AXI_RD_RESP_BACKPRESSURE_EN.
package axi_rd_pkg;

  localparam int unsigned AddrBits      = 64;
  localparam int unsigned BurstLenWidth = 8;
  localparam int unsigned TidWidth      = 8;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_BURST
  } rd_st_t;

  typedef struct packed {
    logic [AddrBits-1:0]      addr;
    logic [BurstLenWidth-1:0] len;
    logic [TidWidth-1:0]      id;
  } ar_req_t;

  // Fibonacci LFSR, taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from the count.
module sync_fifo #(
  parameter int unsigned Width    = 8,
  parameter int unsigned LogDepth = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [Width-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [LogDepth:0]   count_o
);

  localparam int unsigned Depth = 1 << LogDepth;

  logic [Width-1:0]    mem_q [Depth];
  logic [LogDepth-1:0] wptr_q, rptr_q;
  logic [LogDepth:0]   count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == (LogDepth+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read subordinate: queues AR requests, waits crs_latency, returns address-derived INCR bursts.
// Define AXI_RD_RESP_BACKPRESSURE_EN to gate ar_ready / r_valid rise with a free-running LFSR.
module axi_rd_responder
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned DATA_BITS       = 64,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned LOG_AR_DEPTH    = 2,
  parameter int unsigned LAT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ar_valid,
  output logic                       ar_ready,
  input  logic [ADDR_BITS-1:0]       ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] ar_len,
  input  logic [TID_WIDTH-1:0]       ar_id,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_BITS-1:0]       r_data,
  output logic [TID_WIDTH-1:0]       r_id,
  output logic                       r_last,
  input  logic [LAT_WIDTH-1:0]       crs_latency,
  output logic [LOG_AR_DEPTH:0]      outstanding,
  output logic                       busy
);

  localparam int unsigned Step = DATA_BITS / 8;

  ar_req_t                   push_req, pop_req;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [LOG_AR_DEPTH:0]     fifo_count;

  rd_st_t                    st_q, st_d;
  logic                      rdy_en_q;
  logic [ADDR_BITS-1:0]      addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
  logic [LAT_WIDTH-1:0]      lat_q, lat_d;
  logic                      r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [DATA_BITS-1:0]      r_data_q, r_data_d, id_rep;
  logic [TID_WIDTH-1:0]      r_id_q, r_id_d;
  logic [LOG_AR_DEPTH:0]     outst_q, outst_d;
  logic                      ar_gate, r_gate, ar_hs, r_take;

`ifdef AXI_RD_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LfsrSeed;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign ar_gate = lfsr_q[0];
  assign r_gate  = lfsr_q[1];
`else
  assign ar_gate = 1'b1;
  assign r_gate  = 1'b1;
`endif

  // rdy_en_q keeps ar_ready low until the first edge after reset release.
  assign ar_ready = rdy_en_q & ~fifo_full & ar_gate;
  assign ar_hs    = ar_valid & ar_ready;
  assign r_take   = r_valid_q & r_ready;
  assign fifo_pop = (st_q == RD_IDLE) & ~fifo_empty;

  assign push_req = '{addr: AddrBits'(ar_addr), len: BurstLenWidth'(ar_len), id: TidWidth'(ar_id)};

  sync_fifo #(
    .Width    ($bits(ar_req_t)),
    .LogDepth (LOG_AR_DEPTH)
  ) u_ar_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (ar_hs),
    .wdata_i (push_req),
    .pop_i   (fifo_pop),
    .rdata_o (pop_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign id_rep = DATA_BITS'({(DATA_BITS / TID_WIDTH){r_id_q}});

  always_comb begin
    st_d      = st_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    r_data_d  = r_data_q;
    r_id_d    = r_id_q;
    outst_d   = outst_q;

    unique case (st_q)
      RD_IDLE: begin
        if (!fifo_empty) begin
          addr_d = ADDR_BITS'(pop_req.addr);
          len_d  = BURST_LEN_WIDTH'(pop_req.len);
          r_id_d = TID_WIDTH'(pop_req.id);
          beat_d = '0;
          lat_d  = crs_latency;
          st_d   = (crs_latency == '0) ? RD_BURST : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q <= LAT_WIDTH'(1)) st_d = RD_BURST;
        else                        lat_d = lat_q - 1'b1;
      end
      RD_BURST: begin
        if (r_take && r_last_q) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          st_d      = RD_IDLE;
        end else if ((!r_valid_q || r_take) && r_gate) begin
          // Load the next beat; once raised it holds until accepted.
          r_valid_d = 1'b1;
          r_data_d  = DATA_BITS'(addr_q) ^ id_rep;
          r_last_d  = (beat_q == len_q);
          addr_d    = addr_q + ADDR_BITS'(Step);
          beat_d    = beat_q + 1'b1;
        end else if (r_take) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
        end
      end
      default: st_d = RD_IDLE;
    endcase

    unique case ({ar_hs, r_take & r_last_q})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= RD_IDLE;
      rdy_en_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
      outst_q   <= '0;
    end else begin
      st_q      <= st_d;
      rdy_en_q  <= 1'b1;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
      r_data_q  <= r_data_d;
      r_id_q    <= r_id_d;
      outst_q   <= outst_d;
    end
  end

  assign r_valid     = r_valid_q;
  assign r_last      = r_last_q;
  assign r_data      = r_data_q;
  assign r_id        = r_id_q;
  assign outstanding = outst_q;
  assign busy        = (st_q != RD_IDLE) | (fifo_count != '0);

endmodule
